pc_fetch_unit: RTL

//  Upstream neighbour of the microcoded control unit. Holds the 8-bit program counter and
//  the memory address register, and selects the RAM address for instruction/immediate/data fetch.

---
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter, memory address register and RAM address select, plus the
// run/pause/step/halt sequencer that gates CPU progress at fetch boundaries.
module pc_fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ctrlIncrPC,
  input  logic             i_ctrlLoadPC,
  input  logic             i_ctrlPCNOe,
  input  logic             i_ctrlRamAddressEn,
  input  logic             i_ctrlRamSelect,
  input  logic             i_ctrlHlt,
  input  logic             i_stepMode,
  input  logic             i_stepReq,
  input  logic [7:0]       i_bus,
  output logic [7:0]       o_bus,
  output logic             o_busDrive,
  output logic [7:0]       o_ramAddress,
  output logic [7:0]       o_pc,
  output logic             o_run,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_fetchCount
);

  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_STEP  = 2'd2,
    S_HLT   = 2'd3
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_mar;
  logic [CNT_W-1:0]   r_fetchCount;
  logic               r_stepPrev;
  logic               r_run;
  logic               r_halted;

  logic [ADDR_W-1:0]  pcNext;
  logic [ADDR_W-1:0]  marNext;
  logic [CNT_W-1:0]   fetchCountNext;
  logic               active;
  logic               stepEdge;
  logic               doIncr;

  // Next-state, datapath updates and registered status decode.
  always_comb begin
    stateNext      = state;
    pcNext         = r_pc;
    marNext        = r_mar;
    fetchCountNext = r_fetchCount;
    active         = (state == S_RUN) || (state == S_STEP);
    stepEdge       = i_stepReq & ~r_stepPrev;
    doIncr         = active & i_ctrlIncrPC & ~i_ctrlLoadPC;

    if (active) begin
      if (i_ctrlLoadPC) begin
        pcNext = i_bus;
      end else if (i_ctrlIncrPC) begin
        pcNext = r_pc + ADDR_W'(1);
      end
      if (i_ctrlRamAddressEn) begin
        marNext = i_bus;
      end
    end

    // Fetch counter sticks at all-ones.
    if (doIncr && (r_fetchCount != {CNT_W{1'b1}})) begin
      fetchCountNext = r_fetchCount + CNT_W'(1);
    end

    case (state)
      S_RUN: begin
        if (i_ctrlHlt) begin
          stateNext = S_HLT;
        end else if (i_stepMode && i_ctrlIncrPC) begin
          stateNext = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (i_ctrlHlt) begin
          stateNext = S_HLT;
        end else if (!i_stepMode) begin
          stateNext = S_RUN;
        end else if (stepEdge) begin
          stateNext = S_STEP;
        end
      end
      S_STEP: begin
        if (i_ctrlHlt) begin
          stateNext = S_HLT;
        end else if (i_ctrlIncrPC) begin
          stateNext = S_PAUSE;
        end
      end
      default: begin
        stateNext = S_HLT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= i_stepMode ? S_PAUSE : S_RUN;
      r_pc         <= RESET_PC;
      r_mar        <= '0;
      r_fetchCount <= '0;
      r_stepPrev   <= 1'b0;
      r_run        <= ~i_stepMode;
      r_halted     <= 1'b0;
    end else begin
      state        <= stateNext;
      r_pc         <= pcNext;
      r_mar        <= marNext;
      r_fetchCount <= fetchCountNext;
      r_stepPrev   <= i_stepReq;
      r_run        <= (stateNext == S_RUN) || (stateNext == S_STEP);
      r_halted     <= (stateNext == S_HLT);
    end
  end

  // Bus and RAM address paths are combinational off the registered PC/MAR.
  assign o_busDrive   = ~i_ctrlPCNOe;
  assign o_bus        = i_ctrlPCNOe ? '0 : r_pc;
  assign o_ramAddress = i_ctrlRamSelect ? r_mar : r_pc;
  assign o_pc         = r_pc;
  assign o_run        = r_run;
  assign o_halted     = r_halted;
  assign o_fetchCount = r_fetchCount;

endmodule
